// File: rtl/rv32im_alu.sv
// Execute-stage ALU for the RV32IM core: RV32I ops, branch resolution, JALR target,
// single-cycle multiply and a 32-step iterative restoring divider that stalls the pipe.
module rv32im_alu #(
  parameter int data_width = 32
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [5:0]                   ALU_Control,
  input  logic signed [data_width-1:0] operand_A,
  input  logic signed [data_width-1:0] operand_B,
  output logic signed [data_width-1:0] ALU_result,
  output logic                         is_less,
  output logic                         Branch_taken,
  output logic signed [data_width-1:0] JALR_target,
  output logic                         hold_pipeline,
  output logic                         zero
);

  localparam int W = data_width;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} div_state_t;

  function automatic logic [W-1:0] cond_neg(input logic [W-1:0] v, input logic neg);
    return neg ? (~v + 1'b1) : v;
  endfunction

  logic [2:0]   grp, op;
  logic [W-1:0] a_u, b_u, sum, diff, sra_res;
  logic [4:0]   shamt;
  logic         lt_s, lt_u, unsigned_cmp, div_op;

  assign grp          = ALU_Control[5:3];
  assign op           = ALU_Control[2:0];
  assign a_u          = operand_A;
  assign b_u          = operand_B;
  assign shamt        = operand_B[4:0];
  assign sum          = a_u + b_u;
  assign diff         = a_u - b_u;
  assign sra_res      = operand_A >>> shamt;
  assign lt_s         = operand_A < operand_B;
  assign lt_u         = a_u < b_u;
  assign unsigned_cmp = (ALU_Control == 6'b000_011) || (ALU_Control == 6'b010_100) ||
                        (ALU_Control == 6'b010_101);
  assign is_less      = unsigned_cmp ? lt_u : lt_s;
  assign JALR_target  = sum & ~{{(W-1){1'b0}}, 1'b1};
  assign div_op       = (grp == 3'b011) && op[2];

  // One shared 64-bit multiplier; extension of each operand picks MUL/MULH/MULHSU/MULHU.
  logic [2*W-1:0] mul_a, mul_b, prod;
  logic           a_sext, b_sext;

  assign a_sext = (op[1:0] != 2'b11);
  assign b_sext = (op[1] == 1'b0);
  assign mul_a  = {{W{a_sext & operand_A[W-1]}}, a_u};
  assign mul_b  = {{W{b_sext & operand_B[W-1]}}, b_u};
  assign prod   = mul_a * mul_b;

  div_state_t   state;
  logic [W-1:0] quo, rem, dvsr;
  logic [4:0]   count;
  logic         d_rem, neg_a, neg_b, d_zero;
  logic [W:0]   rem_shift, trial;
  logic         fits;
  logic [W-1:0] div_result;
  logic         in_neg_a, in_neg_b;

  assign in_neg_a  = ~op[0] & operand_A[W-1];
  assign in_neg_b  = ~op[0] & operand_B[W-1];
  assign rem_shift = {rem, quo[W-1]};
  assign trial     = rem_shift - {1'b0, dvsr};
  assign fits      = ~trial[W];

  // Signs are applied only at the end; divide-by-zero quotient bypasses the sign fix.
  always_comb begin
    div_result = '0;
    if (d_rem)       div_result = cond_neg(rem, neg_a);
    else if (d_zero) div_result = '1;
    else             div_result = cond_neg(quo, neg_a ^ neg_b);
  end

  // Divider: issue in IDLE, 32 shift-subtract steps in BUSY, result visible in DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      quo    <= '0;
      rem    <= '0;
      dvsr   <= '0;
      count  <= '0;
      d_rem  <= 1'b0;
      neg_a  <= 1'b0;
      neg_b  <= 1'b0;
      d_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: if (div_op) begin
          quo    <= cond_neg(a_u, in_neg_a);
          dvsr   <= cond_neg(b_u, in_neg_b);
          rem    <= '0;
          count  <= '0;
          d_rem  <= op[1];
          neg_a  <= in_neg_a;
          neg_b  <= in_neg_b;
          d_zero <= (b_u == '0);
          state  <= BUSY;
        end
        BUSY: begin
          quo   <= {quo[W-2:0], fits};
          rem   <= fits ? trial[W-1:0] : rem_shift[W-1:0];
          count <= count + 5'd1;
          if (count == 5'd31) state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign hold_pipeline = rst_n && (((state == IDLE) && div_op) || (state == BUSY));

  logic [W-1:0] res;
  logic         taken;

  always_comb begin
    res   = '0;
    taken = 1'b0;
    case (grp)
      3'b000: begin
        case (op)
          3'd0:    res = sum;
          3'd1:    res = a_u << shamt;
          3'd2:    res = {{(W-1){1'b0}}, lt_s};
          3'd3:    res = {{(W-1){1'b0}}, lt_u};
          3'd4:    res = a_u ^ b_u;
          3'd5:    res = a_u >> shamt;
          3'd6:    res = a_u | b_u;
          default: res = a_u & b_u;
        endcase
      end
      3'b001: begin
        if (op == 3'd0)      res = diff;
        else if (op == 3'd5) res = sra_res;
      end
      3'b010: begin
        res = diff;
        case (op)
          3'd0:    taken = (a_u == b_u);
          3'd1:    taken = (a_u != b_u);
          3'd2:    taken = lt_s;
          3'd3:    taken = ~lt_s;
          3'd4:    taken = lt_u;
          3'd5:    taken = ~lt_u;
          3'd6: begin
            res   = sum;
            taken = 1'b1;
          end
          default: begin
            res   = JALR_target;
            taken = 1'b1;
          end
        endcase
      end
      3'b011: begin
        case (op)
          3'd0:    res = prod[W-1:0];
          3'd1,
          3'd2,
          3'd3:    res = prod[2*W-1:W];
          default: res = (state == DONE) ? div_result : '0;
        endcase
      end
      default: ;
    endcase
  end

  assign ALU_result   = res;
  assign Branch_taken = taken;
  assign zero         = (res == '0);

endmodule

// File: tb/tb_rv32im_alu.sv
// Scoreboard bench for rv32im_alu: directed vectors push expectations, a negedge monitor
// pops and compares whenever the ALU is not stalling.
module tb_rv32im_alu;

  typedef struct {
    string       name;
    logic [31:0] res;
    logic        taken;
    logic        chk_lt;
    logic        lt;
    logic        chk_jt;
    logic [31:0] jt;
  } exp_t;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic [5:0]         ALU_Control = 6'd0;
  logic signed [31:0] operand_A = '0;
  logic signed [31:0] operand_B = '0;
  logic signed [31:0] ALU_result;
  logic               is_less, Branch_taken, hold_pipeline, zero;
  logic signed [31:0] JALR_target;

  int   n_checks = 0;
  int   n_fail   = 0;
  logic mon_vld  = 1'b0;
  exp_t sb[$];

  rv32im_alu #(.data_width(32)) dut (
    .clk(clk), .rst_n(rst_n), .ALU_Control(ALU_Control),
    .operand_A(operand_A), .operand_B(operand_B), .ALU_result(ALU_result),
    .is_less(is_less), .Branch_taken(Branch_taken), .JALR_target(JALR_target),
    .hold_pipeline(hold_pipeline), .zero(zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: one comparison set per non-stalled cycle while stimulus is live.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (mon_vld && !hold_pipeline) begin
        if (sb.size() == 0) begin
          chk("unexpected_output", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          chk({e.name, "_result"}, ALU_result, e.res);
          chk({e.name, "_taken"}, {31'd0, Branch_taken}, {31'd0, e.taken});
          chk({e.name, "_zero"}, {31'd0, zero}, {31'd0, (e.res == 32'd0)});
          if (e.chk_lt) chk({e.name, "_is_less"}, {31'd0, is_less}, {31'd0, e.lt});
          if (e.chk_jt) chk({e.name, "_jalr_target"}, JALR_target, e.jt);
        end
      end
    end
  end

  task automatic run(input string name, input logic [5:0] ctrl, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] res, input logic taken,
                     input logic chk_lt, input logic lt, input logic chk_jt,
                     input logic [31:0] jt, input bit is_div);
    exp_t e;
    int   hc;
    @(posedge clk);
    #1;
    ALU_Control = ctrl;
    operand_A   = a;
    operand_B   = b;
    e.name = name; e.res = res; e.taken = taken;
    e.chk_lt = chk_lt; e.lt = lt; e.chk_jt = chk_jt; e.jt = jt;
    sb.push_back(e);
    mon_vld = 1'b1;
    if (is_div) begin
      hc = 0;
      for (int i = 0; i < 100; i++) begin
        @(negedge clk);
        if (!hold_pipeline) break;
        if (i == 0) chk({name, "_busy_result"}, ALU_result, 32'd0);
        hc++;
      end
      chk({name, "_hold_cycles"}, hc, 32'd33);
    end else begin
      @(negedge clk);
    end
  endtask

  localparam logic [5:0] ADD = 6'o00, SLL = 6'o01, SLT = 6'o02, SLTU = 6'o03, XOR_ = 6'o04,
                         SRL = 6'o05, OR_ = 6'o06, AND_ = 6'o07, SUB = 6'o10, SRA = 6'o15,
                         BEQ = 6'o20, BNE = 6'o21, BLT = 6'o22, BGE = 6'o23, BLTU = 6'o24,
                         BGEU = 6'o25, JAL = 6'o26, JALR = 6'o27, MUL = 6'o30, MULH = 6'o31,
                         MULHSU = 6'o32, MULHU = 6'o33, DIV = 6'o34, DIVU = 6'o35,
                         REM = 6'o36, REMU = 6'o37;

  initial begin
    #12;
    chk("reset_hold", {31'd0, hold_pipeline}, 32'd0);
    chk("reset_result", ALU_result, 32'd0);
    chk("reset_zero", {31'd0, zero}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    run("add",    ADD,  32'd10, 32'd5, 32'd15, 0, 0, 0, 0, 0, 0);
    run("sub_eq", SUB,  32'h12345678, 32'h12345678, 32'd0, 0, 0, 0, 0, 0, 0);
    run("sub_neg", SUB, 32'd3, 32'd5, 32'hFFFF_FFFE, 0, 0, 0, 0, 0, 0);
    run("sll",    SLL,  32'd1, 32'd33, 32'd2, 0, 0, 0, 0, 0, 0);
    run("sra",    SRA,  32'h8000_0000, 32'd4, 32'hF800_0000, 0, 0, 0, 0, 0, 0);
    run("srl",    SRL,  32'h8000_0000, 32'd4, 32'h0800_0000, 0, 0, 0, 0, 0, 0);
    run("slt",    SLT,  32'hFFFF_FFFF, 32'd1, 32'd1, 0, 1, 1, 0, 0, 0);
    run("sltu",   SLTU, 32'hFFFF_FFFF, 32'd1, 32'd0, 0, 1, 0, 0, 0, 0);
    run("xor",    XOR_, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_0FF0, 0, 0, 0, 0, 0, 0);
    run("or",     OR_,  32'h0000_F0F0, 32'h0000_FF00, 32'h0000_FFF0, 0, 0, 0, 0, 0, 0);
    run("and",    AND_, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000, 0, 0, 0, 0, 0, 0);
    run("grp1_undef", 6'o11, 32'd9, 32'd3, 32'd0, 0, 0, 0, 0, 0, 0);
    run("beq",    BEQ,  32'd7, 32'd7, 32'd0, 1, 0, 0, 0, 0, 0);
    run("bne",    BNE,  32'd7, 32'd7, 32'd0, 0, 0, 0, 0, 0, 0);
    run("blt",    BLT,  32'hFFFF_FFFB, 32'd2, 32'hFFFF_FFF9, 1, 1, 1, 0, 0, 0);
    run("bge",    BGE,  32'hFFFF_FFFB, 32'd2, 32'hFFFF_FFF9, 0, 1, 1, 0, 0, 0);
    run("bltu",   BLTU, 32'hFFFF_FFFB, 32'd2, 32'hFFFF_FFF9, 0, 1, 0, 0, 0, 0);
    run("bgeu",   BGEU, 32'hFFFF_FFFB, 32'd2, 32'hFFFF_FFF9, 1, 1, 0, 0, 0, 0);
    run("jal",    JAL,  32'h0000_0100, 32'd8, 32'h0000_0108, 1, 0, 0, 0, 0, 0);
    run("jalr",   JALR, 32'h0000_1001, 32'd4, 32'h0000_1004, 1, 0, 0, 1, 32'h0000_1004, 0);
    run("grp4",   6'o40, 32'd10, 32'd5, 32'd0, 0, 0, 0, 0, 0, 0);
    run("mul",    MUL,  32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFEB, 0, 0, 0, 0, 0, 0);
    run("mulh",   MULH, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 0, 0, 0, 0, 0, 0);
    run("mulhsu", MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 0, 0, 0, 0);
    run("mulhu",  MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 0, 0, 0, 0, 0, 0);
    run("div",    DIV,  32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 0, 0, 0, 0, 0, 1);
    run("rem",    REM,  32'd100, 32'hFFFF_FFF9, 32'd2, 0, 0, 0, 0, 0, 1);
    run("rem_negdvd", REM, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE, 0, 0, 0, 0, 0, 1);
    run("divu_zero", DIVU, 32'd7, 32'd0, 32'hFFFF_FFFF, 0, 0, 0, 0, 0, 1);
    run("div_zero_neg", DIV, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFFF, 0, 0, 0, 0, 0, 1);
    run("rem_zero", REM, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 0, 0, 0, 0, 0, 1);
    run("div_ovf", DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0, 0, 0, 0, 0, 1);
    run("rem_ovf", REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 0, 0, 0, 0, 0, 1);
    run("divu",   DIVU, 32'hFFFF_FFFF, 32'd2, 32'h7FFF_FFFF, 0, 0, 0, 0, 0, 1);
    run("remu",   REMU, 32'd100, 32'd7, 32'd2, 0, 0, 0, 0, 0, 1);
    run("add_after_div", ADD, 32'd1, 32'd2, 32'd3, 0, 0, 0, 0, 0, 0);

    // Abort a divide with reset partway through.
    @(posedge clk);
    #1;
    mon_vld     = 1'b0;
    ALU_Control = DIV;
    operand_A   = 32'd100;
    operand_B   = 32'hFFFF_FFF9;
    repeat (5) @(negedge clk);
    chk("abort_hold_before", {31'd0, hold_pipeline}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_hold_in_reset", {31'd0, hold_pipeline}, 32'd0);
    chk("abort_result_in_reset", ALU_result, 32'd0);
    ALU_Control = ADD;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort_hold_after", {31'd0, hold_pipeline}, 32'd0);
    run("add_after_abort", ADD, 32'd20, 32'd22, 32'd42, 0, 0, 0, 0, 0, 0);

    @(posedge clk);
    #1;
    mon_vld = 1'b0;
    repeat (2) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
